// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo_sram write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_REQ = 32;

  // One-hot decode of a requester index; callers cast down to their own width.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    logic [MAX_REQ-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      v[i] = (idx == i);
    end
    return v;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: first set request strictly above last_owner, wrapping to the lowest set request.
module rr_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] masked;
  logic             found;

  always_comb begin
    masked = '0;
    found  = 1'b0;
    idx    = '0;
    vld    = |req;

    for (int unsigned i = 0; i < N_REQ; i++) begin
      masked[i] = req[i] && (IDX_W'(i) > last_owner);
    end

    // Masked search first; unmasked search supplies the wrap-around.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && masked[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the fifo_sram write port among N_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_rdy,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       wr_data,
  output logic                   wr_en,
  input  logic                   wr_full
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  arb_state_e       state_q,      state_d;
  logic [IDX_W-1:0] owner_q,      owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;
  logic [CNT_W-1:0] beat_cnt_q,   beat_cnt_d;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;

  logic             own_vld;
  logic             own_last;
  logic [WIDTH-1:0] own_data;
  logic             xfer;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req        (req_vld),
    .last_owner (last_owner_q),
    .vld        (pick_vld),
    .idx        (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_IDX;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Current owner's request lanes.
  always_comb begin
    own_vld  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_vld  = req_vld[i];
        own_last = req_last[i];
        own_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    gnt          = '0;
    req_rdy      = '0;
    wr_en        = 1'b0;
    wr_data      = '0;
    xfer         = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = BURST;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end

      BURST: begin
        gnt     = N_REQ'(onehot(32'(owner_q)));
        req_rdy = wr_full ? '0 : gnt;
        xfer    = own_vld && !wr_full;
        wr_en   = xfer;
        if (xfer) begin
          wr_data = own_data;
        end

        // Withdrawal, last beat or burst cap all hand priority onward.
        if (!own_vld) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end else if (xfer) begin
          if (own_last || (beat_cnt_q == LAST_BEAT)) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            beat_cnt_d   = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small 8-deep fifo_sram write-side model.
module tb_fifo_wr_arbiter;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_vld;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_rdy;
  logic [3:0]  gnt;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        wr_full;

  logic        rd_en;
  logic        force_full;
  logic        fifo_clr;
  logic [7:0]  fq[$];
  logic [7:0]  wr_log[$];
  logic [7:0]  rd_log[$];
  int          fcnt   = 0;
  int          bad_wr = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ     (4),
    .WIDTH     (8),
    .MAX_BURST (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_last (req_last),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .gnt      (gnt),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .wr_full  (wr_full)
  );

  assign wr_full = (fcnt >= DEPTH) || force_full;

  // fifo_sram write/read side
  always @(posedge clk) begin
    if (wr_en && wr_full) bad_wr++;
    if (fifo_clr) begin
      fq.delete();
      wr_log.delete();
      rd_log.delete();
    end else begin
      if (rd_en && fq.size() > 0) rd_log.push_back(fq.pop_front());
      if (wr_en) begin
        wr_log.push_back(wr_data);
        if (fq.size() < DEPTH) fq.push_back(wr_data);
      end
    end
    fcnt <= fq.size();
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int r, input logic [7:0] d);
    req_data[r*8 +: 8] = d;
  endtask

  logic [7:0] t3_dat [4];

  initial begin
    t3_dat = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    rst = 1'b1; req_vld = 4'hF; req_last = 4'h0; req_data = 32'h0;
    rd_en = 1'b0; force_full = 1'b0; fifo_clr = 1'b1;

    // 1. reset with all requesting, then first grant; reset mid-burst drops it
    next(); settle();
    chk("rst_gnt",     32'(gnt),     32'h0);
    chk("rst_wr_en",   32'(wr_en),   32'h0);
    chk("rst_req_rdy", 32'(req_rdy), 32'h0);
    next(); rst = 1'b0; settle();
    chk("t1_bubble_gnt", 32'(gnt),   32'h0);
    chk("t1_bubble_wr",  32'(wr_en), 32'h0);
    next(); settle();
    chk("t1_first_gnt", 32'(gnt),     32'h1);
    chk("t1_first_rdy", 32'(req_rdy), 32'h1);
    rst = 1'b1;
    next(); settle();
    chk("t1_rst_drop_gnt", 32'(gnt), 32'h0);
    rst = 1'b0; req_vld = 4'h0; fifo_clr = 1'b0;

    // 2. single requester, three beats with last
    next(); req_vld = 4'b0010; set_data(1, 8'h11); settle();
    chk("t2_bubble", 32'(gnt), 32'h0);
    next(); settle();
    chk("t2_gnt",    32'(gnt),     32'h2);
    chk("t2_rdy",    32'(req_rdy), 32'h2);
    chk("t2_wr_en0", 32'(wr_en),   32'h1);
    chk("t2_data0",  32'(wr_data), 32'h11);
    next(); set_data(1, 8'h12); settle();
    chk("t2_data1",  32'(wr_data), 32'h12);
    next(); set_data(1, 8'h13); req_last = 4'b0010; settle();
    chk("t2_wr_en2", 32'(wr_en),   32'h1);
    chk("t2_data2",  32'(wr_data), 32'h13);
    next(); req_vld = 4'h0; req_last = 4'h0; settle();
    chk("t2_idle",   32'(gnt),     32'h0);
    chk("t2_nwr",    32'(wr_log.size()), 32'd3);
    chk("t2_fifo0",  32'(fq[0]), 32'h11);
    chk("t2_fifo1",  32'(fq[1]), 32'h12);
    chk("t2_fifo2",  32'(fq[2]), 32'h13);

    // 3. all four requesting continuously: 0,1,2,3,0 with 4 beats each
    rst = 1'b1; fifo_clr = 1'b1;
    next();
    rst = 1'b0; fifo_clr = 1'b0; rd_en = 1'b1; req_vld = 4'hF;
    for (int r = 0; r < 4; r++) set_data(r, t3_dat[r]);
    settle();
    for (int g = 0; g < 5; g++) begin
      chk("t3_idle_gap", 32'(gnt), 32'h0);
      next(); settle();
      for (int b = 0; b < 4; b++) begin
        chk("t3_gnt",   32'(gnt),     32'(1 << (g % 4)));
        chk("t3_wr_en", 32'(wr_en),   32'h1);
        chk("t3_data",  32'(wr_data), 32'(t3_dat[g % 4]));
        next(); settle();
      end
    end
    chk("t3_end_idle", 32'(gnt), 32'h0);
    req_vld = 4'h0; fifo_clr = 1'b1; rd_en = 1'b0;

    // 4. backpressure mid-burst of req2
    next(); fifo_clr = 1'b0; req_vld = 4'b0100; set_data(2, 8'h41); settle();
    chk("t4_bubble", 32'(gnt), 32'h0);
    next(); settle();
    chk("t4_gnt0",  32'(gnt),     32'h4);
    chk("t4_data0", 32'(wr_data), 32'h41);
    next(); set_data(2, 8'h42); force_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t4_full_wr_en", 32'(wr_en),   32'h0);
      chk("t4_full_gnt",   32'(gnt),     32'h4);
      chk("t4_full_rdy",   32'(req_rdy), 32'h0);
      chk("t4_full_data",  32'(wr_data), 32'h0);
      next();
    end
    force_full = 1'b0; settle();
    chk("t4_resume_wr", 32'(wr_en),   32'h1);
    chk("t4_data1",     32'(wr_data), 32'h42);
    next(); set_data(2, 8'h43); req_last = 4'b0100; settle();
    chk("t4_gnt2",  32'(gnt),     32'h4);
    chk("t4_data2", 32'(wr_data), 32'h43);
    next(); req_vld = 4'h0; req_last = 4'h0; settle();
    chk("t4_idle",  32'(gnt), 32'h0);
    chk("t4_nwr",   32'(wr_log.size()), 32'd3);
    chk("t4_log0",  32'(wr_log[0]), 32'h41);
    chk("t4_log1",  32'(wr_log[1]), 32'h42);
    chk("t4_log2",  32'(wr_log[2]), 32'h43);

    // 5. owner withdraws after one beat; next grant starts after old owner
    req_vld = 4'b1010; set_data(3, 8'h51); set_data(1, 8'h61); settle();
    chk("t5_bubble", 32'(gnt), 32'h0);
    next(); settle();
    chk("t5_gnt3",  32'(gnt),     32'h8);
    chk("t5_data",  32'(wr_data), 32'h51);
    next(); req_vld = 4'b0010; settle();
    chk("t5_wd_gnt",   32'(gnt),     32'h8);
    chk("t5_wd_wr_en", 32'(wr_en),   32'h0);
    chk("t5_wd_rdy",   32'(req_rdy), 32'h8);
    next(); req_vld = 4'b1010; req_last = 4'b0010; settle();
    chk("t5_idle", 32'(gnt), 32'h0);
    next(); settle();
    chk("t5_gnt1",  32'(gnt),     32'h2);
    chk("t5_data1", 32'(wr_data), 32'h61);
    next(); req_vld = 4'h0; req_last = 4'h0; settle();
    chk("t5_end_idle", 32'(gnt), 32'h0);
    chk("t5_nwr",   32'(wr_log.size()), 32'd5);
    chk("t5_log3",  32'(wr_log[3]), 32'h51);
    chk("t5_log4",  32'(wr_log[4]), 32'h61);

    // 6. fill the 8-deep fifo from req3 and req0, hold while full, then drain
    fifo_clr = 1'b1;
    next(); fifo_clr = 1'b0; req_vld = 4'b1001; set_data(3, 8'hD0); set_data(0, 8'hA0); settle();
    chk("t6_bubble", 32'(gnt), 32'h0);
    next();
    for (int b = 0; b < 4; b++) begin
      set_data(3, 8'(8'hD0 + b)); settle();
      chk("t6_gnt3",  32'(gnt),     32'h8);
      chk("t6_wr3",   32'(wr_en),   32'h1);
      chk("t6_data3", 32'(wr_data), 32'(8'(8'hD0 + b)));
      next();
    end
    settle();
    chk("t6_gap", 32'(gnt), 32'h0);
    next();
    for (int b = 0; b < 4; b++) begin
      set_data(0, 8'(8'hA0 + b)); settle();
      chk("t6_gnt0",  32'(gnt),     32'h1);
      chk("t6_wr0",   32'(wr_en),   32'h1);
      chk("t6_data0", 32'(wr_data), 32'(8'(8'hA0 + b)));
      next();
    end
    settle();
    chk("t6_gap2", 32'(gnt), 32'h0);
    next(); settle();
    chk("t6_full_gnt", 32'(gnt),     32'h8);
    chk("t6_full_wr",  32'(wr_en),   32'h0);
    chk("t6_full_rdy", 32'(req_rdy), 32'h0);
    next(); settle();
    chk("t6_full_hold", 32'(gnt),   32'h8);
    chk("t6_full_wr2",  32'(wr_en), 32'h0);
    req_vld = 4'h0;
    next(); rd_en = 1'b1; settle();
    chk("t6_drain_idle", 32'(gnt), 32'h0);
    for (int k = 0; k < 8; k++) next();
    rd_en = 1'b0; settle();
    chk("t6_nwr", 32'(wr_log.size()), 32'd8);
    chk("t6_nrd", 32'(rd_log.size()), 32'd8);
    for (int k = 0; k < 4; k++) begin
      chk("t6_rd3", 32'(rd_log[k]),     32'(8'(8'hD0 + k)));
      chk("t6_rd0", 32'(rd_log[k + 4]), 32'(8'(8'hA0 + k)));
    end
    chk("t6_no_wr_when_full", 32'(bad_wr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
